multichannel_distortion_core: RTL and testbench

Parametrised, time-multiplexed successor to the stereo distortion datapath. It processes NCH audio channels per sample strobe through one shared datapath in the CLOCK_50 domain, with four selectable modes. Mode changes are click-free: a linear crossfade runs over 2^XFADE_SHIFT samples. The block sits between the I2S receiver's sample-valid strobe and the DAC sample registers, and exports mode, fade and clip status for the LCD UI.

---
 rtl/multichannel_distortion_core.sv | 223 ++++++++++++++++++++++
 tb/tb_multichannel_distortion_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_distortion_core.sv
// multichannel_distortion_core
// Time-multiplexed NCH-channel distortion datapath (bypass / hard clip /
// soft clip / fuzz) with a linear crossfade on every mode change. One shared
// shaper evaluates the old and new mode per channel. A signed multiply-shift
// then blends the two results using the fade position k.
module multichannel_distortion_core #(
    parameter int W           = 16,
    parameter int NCH         = 2,
    parameter int XFADE_SHIFT = 6,
    parameter int HARD_THRESH = 8192,
    parameter int GAIN_SHIFT  = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [NCH*W-1:0] in_data,
    input  logic [1:0]       mode_req,
    output logic             out_valid,
    output logic [NCH*W-1:0] out_data,
    output logic             busy,
    output logic [1:0]       mode_cur,
    output logic             fading,
    output logic             clip,
    output logic             overrun
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int K_W  = XFADE_SHIFT + 1;
    localparam int FW   = W + GAIN_SHIFT;
    localparam int PW   = W + XFADE_SHIFT + 3;

    localparam logic [CH_W-1:0]     CH_LAST  = CH_W'(NCH - 1);
    localparam logic [K_W-1:0]      K_LAST   = K_W'((2 ** XFADE_SHIFT) - 1);
    localparam logic signed [W-1:0] S_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] S_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]        THR      = W'(HARD_THRESH);

    typedef enum logic [1:0] {IDLE, CALC, MIX, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CH_W-1:0]        ch;
    logic [1:0]             cur_mode, tgt_mode, new_mode;
    logic [K_W-1:0]         k;
    logic                   clip_acc;
    logic                   start, calc_en, mix_en, done_en, drop;
    logic [NCH*W-1:0]       x_p0;
    logic signed [W-1:0]    x_ch;
    logic signed [W-1:0]    y_old_p1, y_new_p1;
    logic signed [W-1:0]    y_mix;

    // |x| with the most negative code folded onto the largest positive one
    function automatic logic [W-1:0] abs_sat(input logic signed [W-1:0] x);
        logic [W-1:0] r;
        if (x == S_MIN)
            r = S_MAX;
        else if (x[W-1])
            r = -x;
        else
            r = x;
        return r;
    endfunction

    // Fuzz pre-gain before saturation, kept wide so overflow is visible
    function automatic logic signed [FW-1:0] fuzz_wide(input logic signed [W-1:0] x);
        return FW'(x) <<< GAIN_SHIFT;
    endfunction

    // Fuzz gain saturated symmetrically to +/-S_MAX
    function automatic logic signed [W-1:0] fuzz_sat(input logic signed [W-1:0] x);
        logic signed [FW-1:0] fw;
        logic signed [W-1:0]  r;
        fw = fuzz_wide(x);
        if (fw > FW'(S_MAX))
            r = S_MAX;
        else if (fw < -(FW'(S_MAX)))
            r = -S_MAX;
        else
            r = fw[W-1:0];
        return r;
    endfunction

    // Transfer curve f(mode, x)
    function automatic logic signed [W-1:0] shape(input logic [1:0] m,
                                                  input logic signed [W-1:0] x);
        logic [W-1:0]        mag, om;
        logic signed [W-1:0] r;
        mag = abs_sat(x);
        om  = mag;
        if (m == 2'd1 && mag > THR)
            om = THR;
        else if (m == 2'd2 && mag > THR)
            om = THR + ((mag - THR) >> 2);
        case (m)
            2'd0:    r = x;
            2'd3:    r = fuzz_sat(x);
            default: r = x[W-1] ? -om : om;
        endcase
        return r;
    endfunction

    // True when f(mode, x) had to limit the sample
    function automatic logic limits(input logic [1:0] m, input logic signed [W-1:0] x);
        logic signed [FW-1:0] fw;
        logic                 r;
        fw = fuzz_wide(x);
        case (m)
            2'd1, 2'd2: r = (abs_sat(x) > THR);
            2'd3:       r = (fw > FW'(S_MAX)) || (fw < -(FW'(S_MAX)));
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    // y = a + floor((b - a) * k / 2^XFADE_SHIFT); result always lies between a and b
    function automatic logic signed [W-1:0] xfade_mix(input logic signed [W-1:0] a,
                                                      input logic signed [W-1:0] b,
                                                      input logic [K_W-1:0]      kk);
        logic signed [W:0]    d;
        logic signed [PW-1:0] prod, res;
        d    = {b[W-1], b} - {a[W-1], a};
        prod = PW'(d) * $signed(PW'(kk));
        res  = PW'(a) + (prod >>> XFADE_SHIFT);
        return res[W-1:0];
    endfunction

    assign mode_cur = cur_mode;
    assign new_mode = fading ? tgt_mode : cur_mode;
    assign x_ch     = x_p0[ch*W +: W];
    assign y_mix    = xfade_mix(y_old_p1, y_new_p1, k);

    // FSM state register
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: CALC/MIX alternate once per channel
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    state_nxt = MIX;
            MIX:     state_nxt = (ch == CH_LAST) ? DONE : CALC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output decode into datapath enables
    always_comb begin
        start   = (state == IDLE) && in_valid;
        calc_en = (state == CALC);
        mix_en  = (state == MIX);
        done_en = (state == DONE);
        drop    = in_valid && (state != IDLE);
    end

    // Control, fade bookkeeping and output registers
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            ch        <= '0;
            cur_mode  <= 2'd0;
            tgt_mode  <= 2'd0;
            k         <= '0;
            fading    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            clip      <= 1'b0;
            clip_acc  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (drop)
                overrun <= 1'b1;
            if (start) begin
                busy     <= 1'b1;
                ch       <= '0;
                clip_acc <= 1'b0;
                // a new fade starts at k=0, so this very frame is still the old mode
                if (!fading && mode_req != cur_mode) begin
                    tgt_mode <= mode_req;
                    k        <= '0;
                    fading   <= 1'b1;
                end
            end
            if (calc_en)
                clip_acc <= clip_acc | limits(new_mode, x_ch);
            if (mix_en) begin
                out_data[ch*W +: W] <= y_mix;
                if (ch != CH_LAST)
                    ch <= ch + 1'b1;
            end
            if (done_en) begin
                out_valid <= 1'b1;
                busy      <= 1'b0;
                clip      <= clip_acc;
                if (fading) begin
                    if (k == K_LAST) begin
                        cur_mode <= tgt_mode;
                        fading   <= 1'b0;
                        k        <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
            end
        end
    end

    // Frame latch (p0) and per-channel old/new shaper results (p1); data only, FSM gates use
    always_ff @(posedge CLOCK_50) begin
        if (start)
            x_p0 <= in_data;
        if (calc_en) begin
            y_old_p1 <= shape(cur_mode, x_ch);
            y_new_p1 <= shape(new_mode, x_ch);
        end
    end

endmodule

// File: tb/tb_multichannel_distortion_core.sv
// Bench for multichannel_distortion_core: directed frames and randomized frames,
// checked against an integer reference model of the mode/fade rules.
module tb_multichannel_distortion_core;

    localparam int W     = 16;
    localparam int NCH   = 2;
    localparam int XS    = 6;
    localparam int THR   = 8192;
    localparam int GS    = 2;
    localparam int SMAX  = 32767;
    localparam int NFADE = 1 << XS;

    logic             CLOCK_50 = 1'b0;
    logic             reset_n  = 1'b0;
    logic             in_valid = 1'b0;
    logic [NCH*W-1:0] in_data  = '0;
    logic [1:0]       mode_req = 2'd0;
    logic             out_valid;
    logic [NCH*W-1:0] out_data;
    logic             busy;
    logic [1:0]       mode_cur;
    logic             fading;
    logic             clip;
    logic             overrun;

    multichannel_distortion_core #(
        .W(W), .NCH(NCH), .XFADE_SHIFT(XS), .HARD_THRESH(THR), .GAIN_SHIFT(GS)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .mode_req (mode_req),
        .out_valid(out_valid),
        .out_data (out_data),
        .busy     (busy),
        .mode_cur (mode_cur),
        .fading   (fading),
        .clip     (clip),
        .overrun  (overrun)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_cur, m_tgt, m_k;
    bit m_fading;
    int exp_y[NCH];
    bit exp_clip;
    int last_y[NCH];
    bit last_clip;

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_shape(input int m, input int x, output bit c);
        int a, v;
        c = 0;
        a = (x < 0) ? -x : x;
        if (a > SMAX) a = SMAX;
        case (m)
            0: v = x;
            1: begin
                if (a > THR) begin c = 1; v = (x < 0) ? -THR : THR; end
                else v = x;
            end
            2: begin
                if (a > THR) begin
                    c = 1;
                    a = THR + (a - THR) / 4;
                    v = (x < 0) ? -a : a;
                end else v = x;
            end
            default: begin
                v = x * (1 << GS);
                if (v > SMAX) begin c = 1; v = SMAX; end
                else if (v < -SMAX) begin c = 1; v = -SMAX; end
            end
        endcase
        return v;
    endfunction

    function automatic int floor_div(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_tgt = 0; m_k = 0; m_fading = 0;
    endtask

    // one accepted frame: decide fade, compute outputs, advance fade position
    task automatic model_frame(input int l, input int r, input int mreq);
        int xs[NCH];
        int nm, yo, yn;
        bit c0, c1;
        xs[0] = l; xs[1] = r;
        if (!m_fading && mreq != m_cur) begin
            m_tgt = mreq; m_k = 0; m_fading = 1;
        end
        nm = m_fading ? m_tgt : m_cur;
        exp_clip = 0;
        for (int c = 0; c < NCH; c++) begin
            yo = ref_shape(m_cur, xs[c], c0);
            yn = ref_shape(nm, xs[c], c1);
            exp_clip |= c1;
            exp_y[c] = yo + floor_div((yn - yo) * m_k, NFADE);
        end
        if (m_fading) begin
            m_k++;
            if (m_k == NFADE) begin m_cur = m_tgt; m_fading = 0; m_k = 0; end
        end
    endtask

    function automatic int rand_x();
        case ($urandom_range(0, 7))
            0: return -32768;
            1: return 32767;
            2: return THR;
            3: return -THR;
            4: return THR + 1;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic drive(input int l, input int r, input int mreq);
        in_data[0 +: W] = W'(l);
        in_data[W +: W] = W'(r);
        mode_req = 2'(mreq);
    endtask

    task automatic run_frame(input int l, input int r, input int mreq, input bit timing);
        int  n;
        bit  seen;
        model_frame(l, r, mreq);
        @(negedge CLOCK_50);
        drive(l, r, mreq);
        in_valid = 1'b1;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 4*NCH + 8) begin
            if (out_valid) seen = 1;
            else begin
                if (timing && n >= 1) check_val("busy_mid", busy, 1);
                @(negedge CLOCK_50);
                n++;
            end
        end
        if (!seen) begin
            check_val("out_valid_timeout", out_valid, 1);
        end else begin
            check_val("latency", n, 2*NCH + 1);
            for (int c = 0; c < NCH; c++) begin
                last_y[c] = $signed(out_data[c*W +: W]);
                check_val($sformatf("out_ch%0d", c), last_y[c], exp_y[c]);
            end
            last_clip = clip;
            check_val("clip", clip, exp_clip);
            check_val("mode_cur", mode_cur, m_cur);
            check_val("fading", fading, m_fading);
            check_val("busy_done", busy, 0);
            @(negedge CLOCK_50);
            check_val("out_valid_pulse", out_valid, 0);
            check_val("out_hold", $signed(out_data[0 +: W]), exp_y[0]);
        end
    endtask

    task automatic settle(input int mode);
        for (int i = 0; i < 2*NFADE + 4 && (m_cur != mode || m_fading); i++)
            run_frame(rand_x(), rand_x(), mode, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out_valid"}, out_valid, 0);
        check_val({tag, "_out_data"}, out_data, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_mode_cur"}, mode_cur, 0);
        check_val({tag, "_fading"}, fading, 0);
        check_val({tag, "_clip"}, clip, 0);
        check_val({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int cnt, got0, mreq, l2;
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        check_reset_outputs("rst");
        reset_n = 1'b1;

        // bypass, latency and busy window
        run_frame(1234, -32768, 0, 1);
        check_val("t1_l", last_y[0], 1234);
        check_val("t1_r", last_y[1], -32768);
        check_val("t1_clip", last_clip, 0);

        // hard clip steady
        settle(1);
        run_frame(20000, -20000, 1, 0);
        check_val("hard_l", last_y[0], 8192);
        check_val("hard_r", last_y[1], -8192);
        check_val("hard_clip", last_clip, 1);
        run_frame(100, 100, 1, 0);
        check_val("hard_small", last_y[0], 100);
        check_val("hard_small_clip", last_clip, 0);

        // soft clip steady
        settle(2);
        run_frame(20000, -32768, 2, 0);
        check_val("soft_l", last_y[0], 11144);
        check_val("soft_r", last_y[1], -14335);

        // fuzz steady
        settle(3);
        run_frame(5000, -10000, 3, 0);
        check_val("fuzz_l", last_y[0], 20000);
        check_val("fuzz_r", last_y[1], -32767);
        check_val("fuzz_clip", last_clip, 1);

        // 0 -> 1 crossfade, request for mode 3 mid-fade is ignored
        settle(0);
        for (int f = 0; f <= NFADE; f++) begin
            run_frame(20000, rand_x(), (f == 10) ? 3 : 1, 0);
            if (f == 0)  check_val("fade0", last_y[0], 20000);
            if (f == 32) check_val("fade32", last_y[0], 14096);
            if (f == NFADE) begin
                check_val("fade64", last_y[0], 8192);
                check_val("fade64_mode", mode_cur, 1);
                check_val("fade64_fading", fading, 0);
            end
        end

        // overrun: second in_valid two cycles after the first is dropped
        check_val("overrun_pre", overrun, 0);
        model_frame(-5000, 3000, m_cur);
        @(negedge CLOCK_50);
        drive(-5000, 3000, m_cur);
        in_valid = 1'b1;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        @(negedge CLOCK_50);
        drive(7777, -7777, m_cur);
        in_valid = 1'b1;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        cnt = 0; got0 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLOCK_50);
            if (out_valid) begin cnt++; got0 = $signed(out_data[0 +: W]); end
        end
        check_val("overrun_nvalid", cnt, 1);
        check_val("overrun_data", got0, exp_y[0]);
        check_val("overrun_flag", overrun, 1);
        run_frame(rand_x(), rand_x(), m_cur, 0);
        check_val("overrun_sticky", overrun, 1);

        // randomized frames with occasional mode requests
        mreq = m_cur;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) mreq = int'($urandom_range(0, 3));
            run_frame(rand_x(), rand_x(), mreq, 0);
        end
        check_val("overrun_sticky2", overrun, 1);

        // reset during MIX aborts the frame
        @(negedge CLOCK_50);
        l2 = rand_x();
        drive(l2, rand_x(), m_cur);
        in_valid = 1'b1;
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        check_reset_outputs("midrst");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (out_valid) cnt++;
        end
        check_val("midrst_nvalid", cnt, 0);
        model_reset();
        run_frame(-1234, 32767, 0, 1);
        check_val("post_rst_l", last_y[0], -1234);
        check_val("post_rst_r", last_y[1], 32767);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
